seg_scan_capture: RTL and testbench

Receive-side monitor for the two-digit multiplexed 7-segment bus driven by the team's counter/scanner blocks. It samples the anode-select and segment lines every clock, decodes each segment pattern back to BCD, and qualifies each digit position by repeated identical appearances. It publishes a stable tens/units pair plus a binary value, and flags lock, updates and illegal patterns. It sits beside the display driver for self-check, and in benches as the scoreboard front end.

---
 rtl/seg_scan_capture.sv | 167 ++++++++++++++++
 tb/tb_seg_scan_capture.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive-side monitor for the two-digit multiplexed
// 7-segment bus; decodes, qualifies and publishes the displayed value.
module seg_scan_capture #(
    parameter int STABLE_N = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [3:0] an_in,
    input  logic [6:0] seg_in,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [6:0] bin,
    output logic       valid,
    output logic       upd,
    output logic       err
);

    typedef enum logic {
        SYNC,
        LOCKED
    } state_t;

    localparam logic [3:0] RUN_MAX  = 4'(STABLE_N);
    localparam logic [9:0] IDLE_MAX = 10'(TIMEOUT);

    // {legal, digit}; patterns are gfedcba, active-low
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1000000: seg_decode = {1'b1, 4'd0};
            7'b1111001: seg_decode = {1'b1, 4'd1};
            7'b0100100: seg_decode = {1'b1, 4'd2};
            7'b0110000: seg_decode = {1'b1, 4'd3};
            7'b0011001: seg_decode = {1'b1, 4'd4};
            7'b0010010: seg_decode = {1'b1, 4'd5};
            7'b0000010: seg_decode = {1'b1, 4'd6};
            7'b1111000: seg_decode = {1'b1, 4'd7};
            7'b0000000: seg_decode = {1'b1, 4'd8};
            7'b0010000: seg_decode = {1'b1, 4'd9};
            default:    seg_decode = 5'd0;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [1:0][3:0] cand_q, cand_d;
    logic [1:0][3:0] run_q, run_d;
    logic [1:0]      cf_q, cf_d;
    logic [1:0]      sel, conf;
    logic [9:0]      idle_q, idle_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      units_q, units_d;
    logic [6:0]      bin_q, bin_d;
    logic            valid_q, valid_d;
    logic            upd_q, upd_d;
    logic            err_q, err_d;
    logic            legal;
    logic [3:0]      dig;

    always_comb begin
        sel          = {an_in == 4'b1101, an_in == 4'b1110};
        {legal, dig} = seg_decode(seg_in);
        cand_d       = cand_q;
        run_d        = run_q;
        conf         = '0;

        // index 0 tracks the units position, index 1 the tens position
        for (int p = 0; p < 2; p++) begin
            if (sel[p]) begin
                if (!legal) begin
                    run_d[p] = 4'd0;
                end else if (dig != cand_q[p]) begin
                    cand_d[p] = dig;
                    run_d[p]  = 4'd1;
                end else if (run_q[p] != RUN_MAX) begin
                    run_d[p] = run_q[p] + 4'd1;
                end
            end
            conf[p] = (run_d[p] == RUN_MAX) && (run_q[p] != RUN_MAX);
        end

        err_d = (|sel) && !legal;

        if (|sel) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 10'd1;
        end else begin
            idle_d = idle_q;
        end

        state_d = state_q;
        cf_d    = cf_q;
        tens_d  = tens_q;
        units_d = units_q;
        valid_d = valid_q;
        upd_d   = 1'b0;

        unique case (state_q)
            SYNC: begin
                cf_d = cf_q | conf;
                if (&cf_d) begin
                    state_d = LOCKED;
                    cf_d    = '0;
                    valid_d = 1'b1;
                    upd_d   = 1'b1;
                    tens_d  = cand_d[1];
                    units_d = cand_d[0];
                end
            end
            LOCKED: begin
                // a timeout edge is a NONE edge, so it never coincides with a confirmation
                if (idle_d == IDLE_MAX) begin
                    state_d = SYNC;
                    valid_d = 1'b0;
                    cf_d    = '0;
                    run_d   = '0;
                end else if (conf[0] && cand_d[0] != units_q) begin
                    units_d = cand_d[0];
                    upd_d   = 1'b1;
                end else if (conf[1] && cand_d[1] != tens_q) begin
                    tens_d = cand_d[1];
                    upd_d  = 1'b1;
                end
            end
            default: begin
            end
        endcase

        bin_d = 7'd10 * {3'b000, tens_d} + {3'b000, units_d};
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
            cand_q  <= '0;
            run_q   <= '0;
            cf_q    <= '0;
            idle_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
            cf_q    <= cf_d;
            idle_q  <= idle_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

    assign tens  = tens_q;
    assign units = units_q;
    assign bin   = bin_q;
    assign valid = valid_q;
    assign upd   = upd_q;
    assign err   = err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: randomized scoreboard bench for seg_scan_capture
// against a digit-level reference model.
module tb_seg_scan_capture;

    localparam int SN = 3;
    localparam int TO = 16;
    localparam logic [3:0] AN_U = 4'b1110;
    localparam logic [3:0] AN_T = 4'b1101;

    typedef struct packed {
        logic       v;
        logic       u;
        logic       e;
        logic [3:0] t;
        logic [3:0] n;
        logic [6:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] an_in;
    logic [6:0] seg_in;
    logic [3:0] tens, units;
    logic [6:0] bin;
    logic       valid, upd, err;

    always #5 clk = ~clk;

    seg_scan_capture #(
        .STABLE_N(SN),
        .TIMEOUT (TO)
    ) dut (
        .clk_in(clk),
        .rst_n (rst_n),
        .an_in (an_in),
        .seg_in(seg_in),
        .tens  (tens),
        .units (units),
        .bin   (bin),
        .valid (valid),
        .upd   (upd),
        .err   (err)
    );

    logic [6:0] segs [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;
    bit   fin_req = 1'b0;
    exp_t got, want;

    // reference model: digit values, appearance runs, lock flag
    int m_cand[2], m_run[2], m_t, m_u, m_idle;
    bit m_cf[2], m_lock;

    function automatic int seg_value(input logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (segs[i] == s) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_cand[p] = 0;
            m_run[p]  = 0;
            m_cf[p]   = 1'b0;
        end
        m_lock = 1'b0;
        m_t    = 0;
        m_u    = 0;
        m_idle = 0;
    endtask

    function automatic exp_t mk(input bit u, input bit e);
        exp_t r;
        r.v = m_lock;
        r.u = u;
        r.e = e;
        r.t = 4'(m_t);
        r.n = 4'(m_u);
        r.b = 7'(m_t * 10 + m_u);
        return r;
    endfunction

    task automatic model_step(input logic [3:0] an, input logic [6:0] sg);
        int  pos, d;
        bit  eu, ee, confirmed;
        eu = 1'b0;
        ee = 1'b0;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back(mk(1'b0, 1'b0));
            return;
        end
        pos = (an == AN_U) ? 0 : (an == AN_T) ? 1 : -1;
        if (pos < 0) begin
            if (m_idle < TO) m_idle++;
            if (m_lock && m_idle == TO) begin
                m_lock = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    m_cf[p]  = 1'b0;
                    m_run[p] = 0;
                end
            end
        end else begin
            m_idle = 0;
            d = seg_value(sg);
            confirmed = 1'b0;
            if (d < 0) begin
                ee = 1'b1;
                m_run[pos] = 0;
            end else if (d != m_cand[pos]) begin
                m_cand[pos] = d;
                m_run[pos]  = 1;
            end else if (m_run[pos] < SN) begin
                m_run[pos]++;
                confirmed = (m_run[pos] == SN);
            end
            if (confirmed) begin
                if (!m_lock) begin
                    m_cf[pos] = 1'b1;
                    if (m_cf[0] && m_cf[1]) begin
                        m_lock = 1'b1;
                        m_cf[0] = 1'b0;
                        m_cf[1] = 1'b0;
                        m_t = m_cand[1];
                        m_u = m_cand[0];
                        eu = 1'b1;
                    end
                end else if (pos == 0 && m_cand[0] != m_u) begin
                    m_u = m_cand[0];
                    eu  = 1'b1;
                end else if (pos == 1 && m_cand[1] != m_t) begin
                    m_t = m_cand[1];
                    eu  = 1'b1;
                end
            end
        end
        exp_q.push_back(mk(eu, ee));
    endtask

    task automatic cyc(input logic [3:0] an, input logic [6:0] sg);
        an_in  = an;
        seg_in = sg;
        @(posedge clk);
        model_step(an, sg);
        #2;
    endtask

    task automatic pair(input int t, input int u, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(AN_U, segs[u]);
            cyc(AN_T, segs[t]);
        end
    endtask

    always @(negedge clk) begin
        if (fin_req) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expected responses left, want 0",
                         exp_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors",
                     checks, errors);
            $finish;
        end else if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got.v = valid;
            got.u = upd;
            got.e = err;
            got.t = tens;
            got.n = units;
            got.b = bin;
            checks++;
            ncyc++;
            if (got !== want) begin
                errors++;
                $display({"FAIL out cyc=%0d got v=%b upd=%b err=%b t=%0d u=%0d bin=%0d",
                          " want v=%b upd=%b err=%b t=%0d u=%0d bin=%0d"},
                         ncyc, got.v, got.u, got.e, got.t, got.n, got.b,
                         want.v, want.u, want.e, want.t, want.n, want.b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r, n, tv, uv;
        logic [3:0] an;
        logic [6:0] sg;
        rst_n  = 1'b0;
        an_in  = 4'hF;
        seg_in = 7'h7F;
        model_reset();

        pair(4, 7, 2);
        rst_n = 1'b1;
        pair(4, 7, 4);
        cyc(AN_U, 7'h7F);
        pair(4, 7, 3);
        pair(4, 8, 4);
        pair(4, 9, 4);
        pair(9, 9, 4);
        pair(0, 0, 4);
        repeat (TO) cyc(4'hF, segs[8]);
        pair(3, 5, 4);
        repeat (4) begin
            cyc(4'b1100, 7'h7F);
            cyc(4'b0111, segs[1]);
        end
        pair(3, 5, 3);

        tv = 0;
        uv = 0;
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                if ($urandom_range(0, 1) == 1) tv = $urandom_range(0, 9);
                uv = $urandom_range(0, 9);
                n  = $urandom_range(1, 6);
                for (int j = 0; j < n; j++) begin
                    sg = ($urandom_range(0, 19) == 0) ? 7'($urandom) : segs[uv];
                    cyc(AN_U, sg);
                    sg = ($urandom_range(0, 19) == 0) ? 7'($urandom) : segs[tv];
                    cyc(AN_T, sg);
                end
            end else if (r < 85) begin
                n = $urandom_range(1, 24);
                for (int j = 0; j < n; j++) begin
                    an = 4'($urandom);
                    if (an == AN_U || an == AN_T) an = 4'hF;
                    cyc(an, 7'($urandom));
                end
            end else begin
                n = $urandom_range(1, 6);
                for (int j = 0; j < n; j++)
                    cyc(4'($urandom), 7'($urandom));
            end
        end

        pair(2, 6, 4);
        // asynchronous reset between edges: outputs must clear before the next edge
        rst_n = 1'b0;
        model_reset();
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = mk(1'b0, 1'b0);
        pair(1, 1, 2);
        rst_n = 1'b1;
        pair(6, 2, 5);

        @(negedge clk);
        #1;
        fin_req = 1'b1;
    end

endmodule
